// File: rtl/mux_scan_ctrl.sv
// Channel scanner for a 16:1 mux: walks enabled channels, settles, samples, publishes a snapshot.
// Optional MUX_SCAN_CHANGE_EN adds the chg port (per-bit change flags of the last snapshot).
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mask,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] data,
  output logic [1:0]  dbg_state
`ifdef MUX_SCAN_CHANGE_EN
  ,
  output logic [15:0] chg
`endif
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] mask_q;
  logic [15:0] shadow;
  logic [15:0] shadow_nx;
  logic [3:0]  first_ch;
  logic [3:0]  nxt_ch;
  logic        nxt_found;

  assign dbg_state = state;

  // Descending loops so the lowest qualifying channel is the one left standing.
  always_comb begin
    first_ch  = 4'd0;
    nxt_ch    = 4'd0;
    nxt_found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) first_ch = 4'(i);
      if (mask_q[i] && (4'(i) > sel)) begin
        nxt_ch    = 4'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    shadow_nx      = shadow;
    shadow_nx[sel] = mux_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      data   <= 16'd0;
      cnt    <= 4'd0;
      mask_q <= 16'd0;
      shadow <= 16'd0;
`ifdef MUX_SCAN_CHANGE_EN
      chg    <= 16'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (|mask) begin
              mask_q <= mask;
              sel    <= first_ch;
              cnt    <= 4'd0;
              shadow <= data;
              state  <= HOLD;
            end else begin
              // Empty mask: publish immediately, snapshot untouched.
              done  <= 1'b1;
              state <= DONE;
`ifdef MUX_SCAN_CHANGE_EN
              chg   <= 16'd0;
`endif
            end
          end
        end
        HOLD: begin
          if (cnt == SETTLE_C) begin
            shadow <= shadow_nx;
            cnt    <= 4'd0;
            if (nxt_found) begin
              sel <= nxt_ch;
            end else begin
              sel   <= 4'd0;
              data  <= shadow_nx;
              done  <= 1'b1;
              state <= DONE;
`ifdef MUX_SCAN_CHANGE_EN
              chg   <= (shadow_nx ^ data) & mask_q;
`endif
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: queue-based scan model checked every cycle, plus literal scenario checks.
module tb_mux_scan_ctrl;

  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, start0 = 1'b0;
  logic [15:0] mask1 = '0, mask0 = '0, in1 = '0, in0 = '0;
  logic [3:0]  sel1, sel0;
  logic        busy1, busy0, done1, done0;
  logic [15:0] data1, data0;
  logic [1:0]  st1, st0;
  logic [1:0]  idle_st = '0;
  logic        mux1, mux0;
`ifdef MUX_SCAN_CHANGE_EN
  logic [15:0] chg1, chg0;
`endif

  // Behavioural 16:1 muxes standing in for mux16x1.
  assign mux1 = in1[sel1];
  assign mux0 = in0[sel0];

  mux_scan_ctrl #(.SETTLE(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mask(mask1), .mux_out(mux1),
    .sel(sel1), .busy(busy1), .done(done1), .data(data1), .dbg_state(st1)
`ifdef MUX_SCAN_CHANGE_EN
    , .chg(chg1)
`endif
  );

  mux_scan_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mask(mask0), .mux_out(mux0),
    .sel(sel0), .busy(busy0), .done(done0), .data(data0), .dbg_state(st0)
`ifdef MUX_SCAN_CHANGE_EN
    , .chg(chg0)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected outputs per cycle, packed {chg, data, done, busy, sel}.
  typedef logic [37:0] exp_t;
  exp_t        exp_q[$];
  exp_t        cur = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_chg = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      cur    = '0;
      m_data = '0;
      m_chg  = '0;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (!cur[4] && start1) begin
      logic [15:0] old_d, new_d, new_c;
      old_d = m_data;
      new_d = (old_d & ~mask1) | (in1 & mask1);
      new_c = (new_d ^ old_d) & mask1;
      for (int k = 0; k < 16; k++)
        if (mask1[k])
          for (int r = 0; r <= S1; r++)
            exp_q.push_back({m_chg, old_d, 1'b0, 1'b1, 4'(k)});
      exp_q.push_back({new_c, new_d, 1'b1, 1'b1, 4'd0});
      m_data = new_d;
      m_chg  = new_c;
      cur = exp_q.pop_front();
    end else begin
      cur = {m_chg, m_data, 1'b0, 1'b0, 4'd0};
    end
  end

  always @(negedge clk) begin
    chk("sel", 64'(sel1), 64'(cur[3:0]));
    chk("busy", 64'(busy1), 64'(cur[4]));
    chk("done", 64'(done1), 64'(cur[5]));
    chk("data", 64'(data1), 64'(cur[21:6]));
`ifdef MUX_SCAN_CHANGE_EN
    chk("chg", 64'(chg1), 64'(cur[37:22]));
`endif
    if (rst_n) chk("state_vs_busy", 64'(st1 != idle_st), 64'(cur[4]));
  end

  task automatic scan1(input logic [15:0] m, output int cyc);
    @(negedge clk);
    mask1  = m;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int nd;
    int w;
    repeat (3) @(negedge clk);
    chk("rst_sel", 64'(sel1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_data", 64'(data1), 64'd0);
    idle_st = st1;
    rst_n = 1'b1;

    // Full scan, SETTLE=1.
    in1 = 16'hA5C3;
    scan1(16'hFFFF, cyc);
    chk("full_done_cycle", 64'(cyc), 64'd33);
    chk("full_data", 64'(data1), 64'hA5C3);
`ifdef MUX_SCAN_CHANGE_EN
    chk("full_chg", 64'(chg1), 64'hA5C3);
`endif
    @(negedge clk);
    chk("full_busy_after", 64'(busy1), 64'd0);

    // Partial mask, inputs changed.
    in1 = 16'h0000;
    scan1(16'h00F0, cyc);
    chk("part_done_cycle", 64'(cyc), 64'd9);
    chk("part_data", 64'(data1), 64'hA503);
`ifdef MUX_SCAN_CHANGE_EN
    chk("part_chg", 64'(chg1), 64'h00C0);
`endif

    // Empty mask.
    scan1(16'h0000, cyc);
    chk("empty_done_cycle", 64'(cyc), 64'd1);
    chk("empty_sel", 64'(sel1), 64'd0);
    chk("empty_data", 64'(data1), 64'hA503);

    // Repeated starts and mask changes during a scan.
    @(negedge clk);
    in1 = 16'h3C5A;
    mask1 = 16'hFFFF;
    start1 = 1'b1;
    @(negedge clk);
    nd = 0;
    for (int c = 1; c <= 45; c++) begin
      start1 = (c == 2 || c == 5 || c == 10 || c == 33);
      if (c == 3) mask1 = 16'h0001;
      if (done1) nd++;
      @(negedge clk);
    end
    start1 = 1'b0;
    chk("restart_done_count", 64'(nd), 64'd1);
    chk("restart_data", 64'(data1), 64'h3C5A);
`ifdef MUX_SCAN_CHANGE_EN
    chk("restart_chg", 64'(chg1), 64'h9959);
`endif

    // Reset during channel 9.
    in1 = 16'hFFFF;
    mask1 = 16'hFFFF;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    w = 0;
    while (sel1 != 4'd9 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("reached_ch9", 64'(sel1), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 64'(sel1), 64'd0);
    chk("mid_rst_busy", 64'(busy1), 64'd0);
    chk("mid_rst_done", 64'(done1), 64'd0);
    chk("mid_rst_data", 64'(data1), 64'd0);
`ifdef MUX_SCAN_CHANGE_EN
    chk("mid_rst_chg", 64'(chg1), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in1 = 16'h1234;
    scan1(16'h0F0F, cyc);
    chk("post_rst_done_cycle", 64'(cyc), 64'd17);
    chk("post_rst_data", 64'(data1), 64'h0204);

    // SETTLE=0 full scan on the second instance.
    @(negedge clk);
    in0 = 16'hA5C3;
    mask0 = 16'hFFFF;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("s0_done_cycle", 64'(cyc), 64'd17);
    chk("s0_data", 64'(data0), 64'hA5C3);
`ifdef MUX_SCAN_CHANGE_EN
    chk("s0_chg", 64'(chg0), 64'hA5C3);
`endif
    @(negedge clk);
    chk("s0_busy_after", 64'(busy0), 64'd0);
    chk("s0_idle_state", 64'(st0), 64'(idle_st));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
